// File: rtl/ni_flit_tx.sv
// Network-interface flit transmitter: drains a 64-bit FIFO into a credit-flow-controlled router link.
// Optional NI_TX_STATS_EN adds the 16-bit tx_flit_cnt output counting flit_valid pulses.
module ni_flit_tx #(
    parameter int CREDITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [63:0] fifo_data,
    output logic        fifo_read_en,
    output logic        flit_valid,
    output logic [1:0]  flit_type,
    output logic [63:0] flit_data,
    input  logic        credit_in,
    output logic        pkt_busy,
    output logic        credit_err,
`ifdef NI_TX_STATS_EN
    output logic [15:0] tx_flit_cnt,
`endif
    output logic [1:0]  o_dbg_state,
    output logic [3:0]  o_dbg_credit_cnt
);

    // Link handshake: there is no ready. flit_valid is a one-cycle pulse that is only
    // raised while a downstream slot is reserved; credit_in hands one slot back.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam logic [3:0] CREDITS_W = 4'(CREDITS);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_credit_cnt;
    logic [3:0]  w_credit_next;
    logic        w_credit_ovf;
    logic        w_sent;
    logic        w_read_ok;
    logic        w_read_en;
    logic [3:0]  r_rem;
    logic [1:0]  r_flit_type;
    logic [63:0] r_flit_data;
    logic        r_pkt_busy;
    logic        r_credit_err;

    assign w_sent = (r_state == ST_SEND);

    always_comb begin
        w_credit_next = r_credit_cnt;
        w_credit_ovf  = 1'b0;
        case ({w_sent, credit_in})
            2'b10: w_credit_next = r_credit_cnt - 4'd1;
            2'b01: begin
                if (r_credit_cnt == CREDITS_W) begin
                    w_credit_ovf = 1'b1;
                end else begin
                    w_credit_next = r_credit_cnt + 4'd1;
                end
            end
            default: w_credit_next = r_credit_cnt;
        endcase
    end

    // A read is only issued when a slot stays reserved after this cycle's credit update.
    assign w_read_ok = reset && !fifo_empty && (w_credit_next != 4'd0);

    always_comb begin
        w_state_next = r_state;
        w_read_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_read_ok) begin
                    w_read_en    = 1'b1;
                    w_state_next = ST_READ;
                end
            end
            ST_READ: w_state_next = ST_SEND;
            ST_SEND: begin
                if (w_read_ok) begin
                    w_read_en    = 1'b1;
                    w_state_next = ST_READ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_credit_cnt <= CREDITS_W;
            r_credit_err <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_credit_cnt <= w_credit_next;
            if (w_credit_ovf) begin
                r_credit_err <= 1'b1;
            end
        end
    end

    // Framing: a word seen while no packet is open is a head carrying the remaining-flit count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flit_data <= 64'd0;
            r_flit_type <= 2'b00;
            r_pkt_busy  <= 1'b0;
            r_rem       <= 4'd0;
        end else if (r_state == ST_READ) begin
            r_flit_data <= fifo_data;
            if (!r_pkt_busy) begin
                r_rem <= fifo_data[3:0];
                if (fifo_data[3:0] == 4'd0) begin
                    r_flit_type <= 2'b11;
                    r_pkt_busy  <= 1'b0;
                end else begin
                    r_flit_type <= 2'b01;
                    r_pkt_busy  <= 1'b1;
                end
            end else begin
                r_rem <= r_rem - 4'd1;
                if (r_rem == 4'd1) begin
                    r_flit_type <= 2'b10;
                    r_pkt_busy  <= 1'b0;
                end else begin
                    r_flit_type <= 2'b00;
                end
            end
        end
    end

`ifdef NI_TX_STATS_EN
    logic [15:0] r_tx_flit_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_flit_cnt <= 16'd0;
        end else if (w_sent) begin
            r_tx_flit_cnt <= r_tx_flit_cnt + 16'd1;
        end
    end

    assign tx_flit_cnt = r_tx_flit_cnt;
`else
    // Statistics counter not built.
`endif

    assign fifo_read_en     = w_read_en;
    assign flit_valid       = w_sent;
    assign flit_type        = r_flit_type;
    assign flit_data        = r_flit_data;
    assign pkt_busy         = r_pkt_busy;
    assign credit_err       = r_credit_err;
    assign o_dbg_state      = r_state;
    assign o_dbg_credit_cnt = r_credit_cnt;

endmodule

// File: doc/ni_flit_tx.md
NI_FLIT_TX -- requirements
Module: ni_flit_tx

Interface
REQ-001 Parameter: CREDITS, default 4, downstream router input-buffer depth in flits (range 1..15).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port: fifo_empty  input  1  empty flag of the upstream fifo_32x64.
REQ-005 Port: fifo_data  input  64  fifo_32x64 data_out, valid the cycle after a read_en pulse.
REQ-006 Port: fifo_read_en  output  1  read strobe to fifo_32x64, combinational.
REQ-007 Port: flit_valid  output  1  one-cycle pulse, flit presented to router link.
REQ-008 Port: flit_type  output  2  00 body, 01 head, 10 tail, 11 head-tail.
REQ-009 Port: flit_data  output  64  flit payload, registered.
REQ-010 Port: credit_in  input  1  one-cycle pulse, router returned one buffer slot.
REQ-011 Port: pkt_busy  output  1  1 while a multi-flit packet is partially sent.
REQ-012 Port: credit_err  output  1  sticky, credit returned while counter already at CREDITS.

Function
REQ-013 FSM states IDLE, READ, SEND; reset state IDLE.
REQ-014 fifo_read_en SHALL be 1 iff state is IDLE or SEND, fifo_empty=0 and credit_cnt after this cycle's update is nonzero (credit_cnt-sent+credit_in != 0).
REQ-015 IDLE: fifo_read_en=1 -> READ; otherwise stay IDLE.
REQ-016 READ: capture fifo_data into flit_data, compute flit_type -> SEND (exactly one cycle).
REQ-017 SEND: flit_valid=1 for this one cycle; fifo_read_en=1 -> READ, else -> IDLE; peak rate one flit per 2 cycles.
REQ-018 Framing: word captured with pkt_busy=0 is a head; remaining-flit count rem loaded from fifo_data[3:0].
REQ-019 Head with fifo_data[3:0]=0 -> type 11, pkt_busy stays 0; otherwise type 01, pkt_busy=1.
REQ-020 Word captured with pkt_busy=1 decrements rem; type 10 and pkt_busy cleared when rem reaches 0, else type 00.
REQ-021 flit_data SHALL equal the captured word unmodified, held stable until next capture.
REQ-022 credit_cnt (4 bits): -1 on flit_valid cycle, +1 on credit_in, both in one cycle -> unchanged.
REQ-023 credit_in with credit_cnt=CREDITS and no flit_valid: count unchanged, credit_err set to 1 until reset.
REQ-024 credit_cnt SHALL never underflow; REQ-014 guarantees no read issued without a credit reserved.
REQ-025 fifo_empty rising while in READ has no effect; data read already committed.

Reset
REQ-026 reset=0 SHALL immediately force: state IDLE, flit_valid 0, flit_type 00, flit_data 0, pkt_busy 0, rem 0, credit_cnt CREDITS, credit_err 0, fifo_read_en 0.
REQ-027 Reset mid-packet or mid-READ discards the held word and framing state; first word after release is a head.

Configuration
REQ-028 Macro NI_TX_STATS_EN defined: extra port tx_flit_cnt  output  16, counts flit_valid pulses, reset 0, wraps 0xFFFF->0.
REQ-029 NI_TX_STATS_EN undefined: tx_flit_cnt port and counter absent; all other behaviour identical.

Verification
REQ-030 Single word 0x...A5A0 (len 0), credits 4 -> one flit_valid, type 11, data 0x...A5A0, 3 cycles after fifo_empty falls, credit_cnt 3.
REQ-031 Head len 2 + 2 words queued -> types 01,00,10 on flit_valid pulses 2 cycles apart; pkt_busy 1 from head to tail, credit_cnt 1.
REQ-032 CREDITS=4, 6 words queued, no credit_in -> exactly 4 flits sent, fifo_read_en stays 0; one credit_in pulse -> 5th flit sent.
REQ-033 credit_in concurrent with flit_valid at credit_cnt=1 -> credit_cnt stays 1, next read issued without stall.
REQ-034 credit_in with credit_cnt=4 -> credit_err 1, count 4; reset pulse mid-packet -> all outputs per REQ-026, next flit type head.
REQ-035 With NI_TX_STATS_EN: 5 flits sent -> tx_flit_cnt=5; preload via 65536 flits -> wraps to 0.
